// File: rtl/sic_exec_stage_if.sv
// Bus bundle for the SIC execute/writeback stage: instruction intake,
// the combinational ALU hookup and the writeback pulse.
//
// Handshake: an instruction transfers on the rising edge where
// in_valid && in_ready are both high. in_ready is high only while the
// stage is idle. The upstream side holds in_valid/in_opcode/in_operand
// stable until that edge, and the stage ignores in_valid at all other
// times. Writeback has no ready: wb_valid is a one-cycle pulse and the
// consumer must take it in that cycle.
interface sic_exec_stage_if #(
  parameter int DATA_WIDTH   = 24,
  parameter int OPCODE_WIDTH = 6,
  parameter int FLAG_WIDTH   = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [OPCODE_WIDTH-1:0] in_opcode;
  logic [DATA_WIDTH-1:0]   in_operand;
  logic [OPCODE_WIDTH-1:0] alu_opcode;
  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic [FLAG_WIDTH-1:0]   alu_flags;
  logic                    wb_valid;
  logic                    wb_branch_taken;
  logic [DATA_WIDTH-1:0]   wb_target;
  logic                    wb_illegal;
  logic                    wb_div_zero;

  // Environment side: issues instructions, implements the ALU, consumes writeback.
  modport master (
    output in_valid, in_opcode, in_operand, alu_result, alu_flags,
    input  in_ready, alu_opcode, alu_a, alu_b,
    input  wb_valid, wb_branch_taken, wb_target, wb_illegal, wb_div_zero
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_opcode, in_operand, alu_result, alu_flags,
    output in_ready, alu_opcode, alu_a, alu_b,
    output wb_valid, wb_branch_taken, wb_target, wb_illegal, wb_div_zero
  );
endinterface

// File: rtl/sic_exec_stage.sv
// SIC execute/writeback stage. Owns the accumulator A and the condition
// codes CC, uses the external ALU for ADD/SUB/COMP, and runs MUL (shift-add,
// multiplier LSB first) and DIV (restoring, quotient MSB first) itself over
// 24 iterations. Every accepted instruction retires with one wb_valid pulse.
module sic_exec_stage #(
  parameter int DATA_WIDTH   = 24,
  parameter int OPCODE_WIDTH = 6,
  parameter int FLAG_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sic_exec_stage_if.slave       bus,
  output logic [DATA_WIDTH-1:0] acc_q,
  output logic [FLAG_WIDTH-1:0] cc_q,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2, S_DIV = 2'd3} state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA  = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 6'h18;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 6'h1C;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV  = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_COMP = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_JEQ  = 6'h30;
  localparam logic [OPCODE_WIDTH-1:0] OP_JGT  = 6'h34;
  localparam logic [OPCODE_WIDTH-1:0] OP_JLT  = 6'h38;

  localparam logic [FLAG_WIDTH-1:0] CC_EQ = 3'b100;
  localparam logic [FLAG_WIDTH-1:0] CC_LT = 3'b010;
  localparam logic [FLAG_WIDTH-1:0] CC_GT = 3'b001;

  // Last iteration index; also the bit position of the dividend MSB.
  localparam logic [4:0] LAST = 5'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_d;
  logic [FLAG_WIDTH-1:0]   cc_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;   // MUL partial product / DIV quotient
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;     // DIV partial remainder
  logic                    wb_valid_q, wb_valid_d;
  logic                    wb_taken_q, wb_taken_d;
  logic [DATA_WIDTH-1:0]   wb_target_q, wb_target_d;
  logic                    wb_illegal_q, wb_illegal_d;
  logic                    wb_div_zero_q, wb_div_zero_d;

  // A does not change while MUL/DIV iterate, so it serves directly as the
  // multiplicand and as the dividend bit source.
  logic [DATA_WIDTH-1:0] mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_quo;
  logic [DATA_WIDTH-1:0] div_rem;

  assign mul_sum   = opnd_q[cnt_q] ? (work_q + (acc_q << cnt_q)) : work_q;
  assign div_shift = {rem_q, acc_q[LAST - cnt_q]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_rem   = div_ge ? (div_shift[DATA_WIDTH-1:0] - opnd_q) : div_shift[DATA_WIDTH-1:0];
  assign div_quo   = {work_q[DATA_WIDTH-2:0], div_ge};

  assign bus.in_ready        = (state_q == S_IDLE);
  assign bus.alu_opcode      = op_q;
  assign bus.alu_a           = acc_q;
  assign bus.alu_b           = opnd_q;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_branch_taken = wb_taken_q;
  assign bus.wb_target       = wb_target_q;
  assign bus.wb_illegal      = wb_illegal_q;
  assign bus.wb_div_zero     = wb_div_zero_q;
  assign dbg_state           = state_q;

  // Next-state, datapath and writeback decode; wb flags default low so they
  // read 0 whenever no commit happens in this cycle.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cc_d          = cc_q;
    op_d          = op_q;
    opnd_d        = opnd_q;
    cnt_d         = cnt_q;
    work_d        = work_q;
    rem_d         = rem_q;
    wb_valid_d    = 1'b0;
    wb_taken_d    = 1'b0;
    wb_target_d   = wb_target_q;
    wb_illegal_d  = 1'b0;
    wb_div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d   = bus.in_opcode;
          opnd_d = bus.in_operand;
          cnt_d  = '0;
          work_d = '0;
          rem_d  = '0;
          if (bus.in_opcode == OP_MUL) begin
            state_d = S_MUL;
          end else if (bus.in_opcode == OP_DIV && bus.in_operand != '0) begin
            state_d = S_DIV;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d    = S_IDLE;
        wb_valid_d = 1'b1;
        case (op_q)
          OP_LDA:         acc_d = opnd_q;
          OP_ADD, OP_SUB: acc_d = bus.alu_result;
          OP_COMP:        cc_d  = bus.alu_flags;
          OP_JEQ: begin
            wb_target_d = opnd_q;
            wb_taken_d  = (cc_q == CC_EQ);
          end
          OP_JGT: begin
            wb_target_d = opnd_q;
            wb_taken_d  = (cc_q == CC_GT);
          end
          OP_JLT: begin
            wb_target_d = opnd_q;
            wb_taken_d  = (cc_q == CC_LT);
          end
          OP_DIV: begin
            // Only a zero divisor reaches EXEC with DIV.
            acc_d         = '1;
            wb_div_zero_d = 1'b1;
          end
          default:        wb_illegal_d = 1'b1;
        endcase
      end
      S_MUL: begin
        work_d = mul_sum;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          acc_d      = mul_sum;
          wb_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_DIV: begin
        work_d = div_quo;
        rem_d  = div_rem;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          acc_d      = div_quo;
          wb_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any iteration in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cc_q          <= '0;
      op_q          <= '0;
      opnd_q        <= '0;
      cnt_q         <= '0;
      work_q        <= '0;
      rem_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_taken_q    <= 1'b0;
      wb_target_q   <= '0;
      wb_illegal_q  <= 1'b0;
      wb_div_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cc_q          <= cc_d;
      op_q          <= op_d;
      opnd_q        <= opnd_d;
      cnt_q         <= cnt_d;
      work_q        <= work_d;
      rem_q         <= rem_d;
      wb_valid_q    <= wb_valid_d;
      wb_taken_q    <= wb_taken_d;
      wb_target_q   <= wb_target_d;
      wb_illegal_q  <= wb_illegal_d;
      wb_div_zero_q <= wb_div_zero_d;
    end
  end

endmodule

// File: tb/tb_sic_exec_stage.sv
// Bench for sic_exec_stage: directed sequences plus randomized instruction
// streams, checked by a scoreboard fed from an arithmetic reference model.
module tb_sic_exec_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sic_exec_stage_if bus ();
  logic [23:0] acc_q;
  logic [2:0]  cc_q;
  logic [1:0]  dbg_state;

  sic_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .acc_q     (acc_q),
    .cc_q      (cc_q),
    .dbg_state (dbg_state)
  );

  // Combinational ALU: ADD/SUB results, unsigned compare flags A vs operand.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_opcode)
      6'h18:   bus.alu_result = bus.alu_a + bus.alu_b;
      6'h1C:   bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    if (bus.alu_a == bus.alu_b)     bus.alu_flags = 3'b100;
    else if (bus.alu_a < bus.alu_b) bus.alu_flags = 3'b010;
    else                            bus.alu_flags = 3'b001;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [23:0] acc;
    logic [2:0]  cc;
    logic        taken;
    logic [23:0] target;
    logic        ill;
    logic        dz;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int n_wb = 0;

  logic [23:0] m_acc = '0;
  logic [2:0]  m_cc = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per writeback pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.wb_valid) begin
        n_wb++;
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_latency", cyc, e.due);
          chk("wb_acc", acc_q, e.acc);
          chk("wb_cc", cc_q, e.cc);
          chk("wb_taken", bus.wb_branch_taken, e.taken);
          chk("wb_illegal", bus.wb_illegal, e.ill);
          chk("wb_div_zero", bus.wb_div_zero, e.dz);
          if (e.taken) chk("wb_target", bus.wb_target, e.target);
        end
      end else begin
        chk("wb_flags_idle", {bus.wb_branch_taken, bus.wb_illegal, bus.wb_div_zero}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [23:0] opnd);
    int   n;
    int   lat;
    exp_t e;
    logic [47:0] prod;
    n = 0;
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_operand = opnd;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("issue_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
      return;
    end
    lat      = 1;
    e.taken  = 1'b0;
    e.target = opnd;
    e.ill    = 1'b0;
    e.dz     = 1'b0;
    case (op)
      6'h00: m_acc = opnd;
      6'h18: m_acc = m_acc + opnd;
      6'h1C: m_acc = m_acc - opnd;
      6'h28: m_cc = (m_acc == opnd) ? 3'b100 : ((m_acc < opnd) ? 3'b010 : 3'b001);
      6'h30: e.taken = (m_cc == 3'b100);
      6'h34: e.taken = (m_cc == 3'b001);
      6'h38: e.taken = (m_cc == 3'b010);
      6'h20: begin
        prod  = 48'(m_acc) * 48'(opnd);
        m_acc = prod[23:0];
        lat   = 24;
      end
      6'h24: begin
        if (opnd == 24'd0) begin
          m_acc = 24'hFFFFFF;
          e.dz  = 1'b1;
        end else begin
          m_acc = m_acc / opnd;
          lat   = 24;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.acc = m_acc;
    e.cc  = m_cc;
    e.due = cyc + 1 + lat;
    exp_q.push_back(e);
    n_acc++;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_acc"}, acc_q, 32'd0);
    chk({tag, "_cc"}, cc_q, 32'd0);
    chk({tag, "_in_ready"}, bus.in_ready, 32'd1);
    chk({tag, "_wb_valid"}, bus.wb_valid, 32'd0);
    chk({tag, "_wb_flags"}, {bus.wb_branch_taken, bus.wb_illegal, bus.wb_div_zero}, 32'd0);
    chk({tag, "_wb_target"}, bus.wb_target, 32'd0);
    chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
    chk({tag, "_alu_op"}, bus.alu_opcode, 32'd0);
    chk({tag, "_state"}, dbg_state, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] ill_ops [4] = '{6'h01, 6'h3F, 6'h2C, 6'h10};

  initial begin
    logic [5:0]  op;
    logic [23:0] opnd;
    bus.in_valid   = 1'b0;
    bus.in_opcode  = '0;
    bus.in_operand = '0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back single-cycle ops and unsigned wrap
    issue(6'h00, 24'h000005);
    issue(6'h18, 24'h000003);
    drain();
    chk("add_result", acc_q, 32'h000008);
    issue(6'h1C, 24'h00000A);
    drain();
    chk("sub_wrap", acc_q, 32'hFFFFFE);

    // Compare and conditional jumps
    issue(6'h00, 24'd7);
    issue(6'h28, 24'd7);
    drain();
    chk("comp_eq", cc_q, 32'b100);
    issue(6'h30, 24'h000100);
    issue(6'h38, 24'h000200);
    issue(6'h28, 24'd9);
    drain();
    chk("comp_lt", cc_q, 32'b010);

    // MUL truncation and small product
    issue(6'h00, 24'h001000);
    issue(6'h20, 24'h001000);
    drain();
    chk("mul_trunc", acc_q, 32'h000000);
    issue(6'h00, 24'h000007);
    issue(6'h20, 24'h000003);
    drain();
    chk("mul_small", acc_q, 32'h000015);

    // DIV and divide by zero
    issue(6'h00, 24'd100);
    issue(6'h24, 24'd7);
    drain();
    chk("div_result", acc_q, 32'd14);
    issue(6'h24, 24'd0);
    drain();
    chk("div_zero_acc", acc_q, 32'hFFFFFF);

    // Illegal opcode leaves A and CC alone
    issue(6'h3F, 24'h123456);
    drain();
    chk("illegal_acc", acc_q, 32'hFFFFFF);
    chk("illegal_cc", cc_q, 32'b010);

    // in_valid while MUL is busy must be ignored
    issue(6'h00, 24'h000009);
    issue(6'h20, 24'h000005);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = 6'h00;
    bus.in_operand = 24'h00ABCD;
    for (int i = 0; i < 3; i++) begin
      chk("busy_in_ready", bus.in_ready, 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("mul_busy_result", acc_q, 32'd45);

    // Reset in the middle of DIV
    issue(6'h00, 24'd100);
    issue(6'h24, 24'd7);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_values("async_reset");
    exp_q.delete();
    n_acc = n_acc - 1;
    m_acc = '0;
    m_cc  = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    issue(6'h00, 24'd42);
    drain();
    chk("post_reset_lda", acc_q, 32'd42);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: op = 6'h00;
        1: op = 6'h18;
        2: op = 6'h1C;
        3: op = 6'h28;
        4: op = 6'h30;
        5: op = 6'h34;
        6: op = 6'h38;
        7: op = 6'h20;
        8: op = 6'h24;
        default: op = ill_ops[$urandom_range(0, 3)];
      endcase
      case ($urandom_range(0, 3))
        0: opnd = 24'($urandom_range(0, 15));
        1: opnd = 24'($urandom);
        2: opnd = m_acc;
        default: opnd = 24'hFFFFFF - 24'($urandom_range(0, 3));
      endcase
      issue(op, opnd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    chk("wb_count", n_wb, n_acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sic_exec_stage.md
# sic_exec_stage

Execute/writeback stage of the SIC datapath, directly downstream of the combinational 24-bit ALU. It owns the accumulator (A) and condition-code (CC) registers. It accepts one decoded instruction at a time through a valid/ready handshake, drives the ALU for ADD/SUB/COMP, and runs MUL and DIV itself as 24-cycle iterative units. It resolves JEQ/JGT/JLT against CC and emits a one-cycle writeback pulse per instruction.

## Interface
- DATA_WIDTH, 24, word width of A, operand and ALU ports
- OPCODE_WIDTH, 6, opcode width
- FLAG_WIDTH, 3, CC/flag width; encoding 100=EQ, 010=LT, 001=GT
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept; high only in IDLE
- in_opcode  in  OPCODE_WIDTH  instruction opcode
- in_operand  in  DATA_WIDTH  resolved memory operand / target address
- alu_opcode  out  OPCODE_WIDTH  latched opcode to ALU
- alu_a  out  DATA_WIDTH  current A register to ALU
- alu_b  out  DATA_WIDTH  latched operand to ALU
- alu_result  in  DATA_WIDTH  ALU result
- alu_flags  in  FLAG_WIDTH  ALU compare flags
- wb_valid  out  1  one-cycle pulse: instruction retired
- wb_branch_taken  out  1  valid with wb_valid; conditional jump taken
- wb_target  out  DATA_WIDTH  jump target; valid when wb_branch_taken
- wb_illegal  out  1  valid with wb_valid; opcode unsupported
- wb_div_zero  out  1  valid with wb_valid; DIV with operand 0
- acc_q  out  DATA_WIDTH  A register
- cc_q  out  FLAG_WIDTH  CC register

## Operation
- States: IDLE, EXEC, MUL, DIV. Accept on the rising edge where in_valid && in_ready. On accept, latch opcode and operand. Next state is MUL for 0x20, DIV for 0x24 with operand != 0, otherwise EXEC.
- EXEC behaviour by opcode:
  - LDA 0x00: A <= operand.
  - ADD 0x18 / SUB 0x1C: A <= alu_result, mod 2^24 wrap, unsigned.
  - COMP 0x28: CC <= alu_flags; A unchanged.
  - JEQ 0x30 / JGT 0x34 / JLT 0x38: taken iff CC equals 100 / 001 / 010 respectively; wb_target <= operand.
  - DIV with operand 0: A <= 24'hFFFFFF, wb_div_zero=1.
  - Any other opcode: no register change, wb_illegal=1.
  - EXEC always returns to IDLE.
- MUL: shift-add over 24 iterations, one multiplier bit per cycle, LSB first. A <= low 24 bits of A*operand (unsigned); upper bits discarded. CC unchanged.
- DIV: restoring division, 24 iterations, one quotient bit per cycle, MSB first. A <= floor(A/operand), unsigned; remainder discarded. CC unchanged.
- Iteration counter 5 bits, 0..23. The commit happens on the edge where the counter = 23, then the state returns to IDLE.
- wb_* outputs are registered. They are set on the commit edge, and wb_valid drops the following edge unless another commit occurs. wb_branch_taken, wb_illegal and wb_div_zero read 0 whenever wb_valid = 0.
- No backpressure on writeback; the consumer must sample it in the pulse cycle.
- alu_a = acc_q and alu_b = latched operand at all times. The ALU result is used only in EXEC.

## Timing
- Reset (async): state=IDLE, A=0, CC=000, operand/opcode latches=0, counter=0, wb_valid=0, wb_branch_taken=0, wb_target=0, wb_illegal=0, wb_div_zero=0; in_ready=1 immediately.
- Single-cycle ops: accept edge E0, commit edge E1, wb_valid high in cycle after E1. in_ready is high in that same cycle, so back-to-back issue is possible: one instruction per 2 cycles.
- MUL/DIV: accept E0, commit E24, wb_valid in the cycle after E24; in_ready low for cycles E0..E24.
- in_valid while busy: ignored, not latched. The upstream stage must hold the instruction until in_ready.
- A COMP followed immediately by a Jxx sees the updated CC, because the commit precedes the next accept.
- Reset asserted mid-MUL/DIV: the operation is abandoned, A is cleared, and no wb_valid is produced.

## Test plan
- Reset, then LDA 0x000005, ADD 0x000003: wb_valid at cycles 2 and 4 after first accept; acc_q=0x000008; SUB 0x00000A gives acc_q=0xFFFFFE (wrap).
- LDA 7, COMP 7 gives cc_q=100. JEQ 0x000100 gives wb_branch_taken=1, wb_target=0x000100. JLT 0x000200 gives taken=0. COMP 9 gives cc_q=010.
- LDA 0x001000, MUL 0x001000: in_ready low 25 cycles, wb_valid exactly 25 cycles after accept, acc_q=0x000000 (truncated). MUL 0x000003 from A=0x000007 gives 0x000015.
- LDA 100, DIV 7 gives acc_q=14 after 25 cycles. DIV 0 gives 1-cycle retire, acc_q=0xFFFFFF, wb_div_zero=1.
- Opcode 0x3F gives wb_illegal=1 with acc_q and cc_q unchanged. in_valid pulsed during MUL is ignored, and the count of wb_valid pulses equals accepted instructions.
- Assert rst at iteration 10 of DIV: all outputs are at reset values asynchronously, and no wb_valid follows. The next LDA completes normally.
